// File: rtl/count_scan_disp.sv
// rtl/count_scan_disp.sv - extends a 4-bit ripple counter to 16 bits and scans it onto a 4-digit 7-segment display
// Optional feature macro: LEADING_ZERO_BLANK_EN (darkens leading zero digits 3..1)
module count_scan_disp #(
    parameter int SCAN_DIV = 50000,
    parameter int DP_DIGIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] q_in,
    input  logic       rc_in,
    input  logic       clr,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       ovf
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam bit DP_VALID = (DP_DIGIT >= 0) && (DP_DIGIT <= 3);
    localparam logic [1:0] DP_IDX = DP_VALID ? 2'(DP_DIGIT) : 2'd0;

    logic [3:0]    r_d0;
    logic [3:0]    r_d1;
    logic [3:0]    r_d2;
    logic [3:0]    r_d3;
    logic          r_ovf;
    logic [CW-1:0] r_scan_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    logic [3:0]    w_digit;
    logic [6:0]    w_dec;
    logic          w_blank;
    logic          w_dp_on;
    logic          w_scan_wrap;

    assign w_scan_wrap = (r_scan_cnt == CNT_MAX);
    assign w_dp_on     = DP_VALID && (r_idx == DP_IDX);

    // Digit chain: clr wins over a coincident carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0  <= 4'h0;
            r_d1  <= 4'h0;
            r_d2  <= 4'h0;
            r_d3  <= 4'h0;
            r_ovf <= 1'b0;
        end else begin
            r_d0 <= q_in;
            if (clr) begin
                r_d1  <= 4'h0;
                r_d2  <= 4'h0;
                r_d3  <= 4'h0;
                r_ovf <= 1'b0;
            end else if (rc_in) begin
                r_d1 <= r_d1 + 4'h1;
                if (r_d1 == 4'hF) begin
                    r_d2 <= r_d2 + 4'h1;
                    if (r_d2 == 4'hF) begin
                        r_d3 <= r_d3 + 4'h1;
                        if (r_d3 == 4'hF) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else begin
            if (w_scan_wrap) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_digit = r_d0;
        case (r_idx)
            2'd0:    w_digit = r_d0;
            2'd1:    w_digit = r_d1;
            2'd2:    w_digit = r_d2;
            default: w_digit = r_d3;
        endcase
    end

    always_comb begin
        w_dec = 7'h7F;
        case (w_digit)
            4'h0: w_dec = 7'h40;
            4'h1: w_dec = 7'h79;
            4'h2: w_dec = 7'h24;
            4'h3: w_dec = 7'h30;
            4'h4: w_dec = 7'h19;
            4'h5: w_dec = 7'h12;
            4'h6: w_dec = 7'h02;
            4'h7: w_dec = 7'h78;
            4'h8: w_dec = 7'h00;
            4'h9: w_dec = 7'h10;
            4'hA: w_dec = 7'h08;
            4'hB: w_dec = 7'h03;
            4'hC: w_dec = 7'h46;
            4'hD: w_dec = 7'h21;
            4'hE: w_dec = 7'h06;
            default: w_dec = 7'h0E;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A slot is dark only while it and every more significant digit are zero
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd3:    w_blank = (r_d3 == 4'h0);
            2'd2:    w_blank = (r_d3 == 4'h0) && (r_d2 == 4'h0);
            2'd1:    w_blank = (r_d3 == 4'h0) && (r_d2 == 4'h0) && (r_d1 == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'hF;
            r_seg <= 8'hFF;
        end else if (w_blank) begin
            r_an  <= 4'hF;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= {~w_dp_on, w_dec};
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_count_scan_disp.sv
// tb/tb_count_scan_disp.sv - scoreboard bench for count_scan_disp with SCAN_DIV=4, DP_DIGIT=0
module tb_count_scan_disp;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] q_in;
    logic       rc_in;
    logic       clr;
    logic [3:0] an;
    logic [7:0] seg;
    logic       ovf;

    count_scan_disp #(.SCAN_DIV(4), .DP_DIGIT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q_in  (q_in),
        .rc_in (rc_in),
        .clr   (clr),
        .an    (an),
        .seg   (seg),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         mode;   // 1: compare at the next sample; 0: compare when slot is shown
        int         slot;
        logic [3:0] an;
        logic [7:0] seg;
        logic       ovf;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic compare(input string name, input logic [3:0] a, input logic [7:0] s,
                           input logic o, input logic [3:0] ea, input logic [7:0] es,
                           input logic eo);
        vectors++;
        if (a !== ea || s !== es || o !== eo) begin
            miscompares++;
            $display("FAIL %s: got an=%h seg=%h ovf=%b, expected an=%h seg=%h ovf=%b",
                     name, a, s, o, ea, es, eo);
        end
    endtask

    task automatic push(input bit mode, input string name, input int slot,
                        input logic [6:0] seg7, input logic o, input bit blank);
        exp_t e;
        logic [3:0] a;
        a = 4'b0001 << slot;
        e.mode = mode;
        e.slot = slot;
        e.name = name;
        e.ovf  = o;
        if (blank) begin
            e.an  = 4'hF;
            e.seg = 8'hFF;
        end else begin
            e.an  = ~a;
            e.seg = {(slot == 0) ? 1'b0 : 1'b1, seg7};
        end
        sb.push_back(e);
    endtask

    // Monitor: slot k of a scan is shown 4*k cycles after an first goes to E
    initial begin
        exp_t       e;
        logic [3:0] prev_an;
        int         phase;
        int         budget;
        prev_an = 4'hF;
        phase   = -1;
        budget  = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                phase  = -1;
                budget = 0;
            end else begin
                e = sb[0];
                if (e.mode) begin
                    void'(sb.pop_front());
                    compare(e.name, an, seg, ovf, e.an, e.seg, e.ovf);
                end else begin
                    if (phase < 0 && an == 4'hE && prev_an != 4'hE) phase = 0;
                    if (phase >= 0 && phase == 4 * e.slot) begin
                        void'(sb.pop_front());
                        compare(e.name, an, seg, ovf, e.an, e.seg, e.ovf);
                        phase  = -1;
                        budget = 0;
                    end else begin
                        if (phase >= 0) phase++;
                        budget++;
                        if (budget > 80) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL %s: slot %0d never shown (an=%h), expected within 80 cycles",
                                     e.name, e.slot, an);
                            void'(sb.pop_front());
                            phase  = -1;
                            budget = 0;
                        end
                    end
                end
            end
            prev_an = an;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sb();
        int t = 0;
        while (sb.size() > 0 && t < 300) begin
            step();
            t++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic inc(input int n);
        q_in  = 4'hF;
        rc_in = 1'b1;
        repeat (n) step();
        rc_in = 1'b0;
        q_in  = 4'h0;
        step();
        step();
    endtask

    task automatic sweep(input int n);
        repeat (n) begin
            for (int v = 0; v < 16; v++) begin
                q_in  = 4'(v);
                rc_in = (v == 15);
                step();
            end
        end
        rc_in = 1'b0;
        q_in  = 4'h0;
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        q_in  = 4'h0;
        rc_in = 1'b0;
        clr   = 1'b0;
        repeat (3) step();
        compare("reset_hold", an, seg, ovf, 4'hF, 8'hFF, 1'b0);

        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int s;
            s = (i / 4) % 4;
            push(1'b1, $sformatf("scan_seq_%0d", i), s, 7'h40, 1'b0, LZB && (s != 0));
        end
        wait_sb();

        // 17 wraps: d3=0 d2=1 d1=1
        sweep(17);
        push(1'b0, "carry_slot0", 0, 7'h40, 1'b0, 1'b0);
        push(1'b0, "carry_slot1", 1, 7'h79, 1'b0, 1'b0);
        push(1'b0, "carry_slot2", 2, 7'h79, 1'b0, 1'b0);
        push(1'b0, "carry_slot3", 3, 7'h40, 1'b0, LZB);
        wait_sb();

        // 256 wraps total: d3=1 d2=0 d1=0
        inc(256 - 17);
        push(1'b0, "w256_slot3", 3, 7'h79, 1'b0, 1'b0);
        push(1'b0, "w256_slot2", 2, 7'h40, 1'b0, 1'b0);
        push(1'b0, "w256_slot1", 1, 7'h40, 1'b0, 1'b0);
        wait_sb();

        // 4095 wraps: all upper digits F
        inc(4095 - 256);
        push(1'b0, "fff_slot3", 3, 7'h0E, 1'b0, 1'b0);
        push(1'b0, "fff_slot1", 1, 7'h0E, 1'b0, 1'b0);
        wait_sb();

        inc(1);
        push(1'b0, "ovf_slot1", 1, 7'h40, 1'b1, LZB);
        push(1'b0, "ovf_slot3", 3, 7'h40, 1'b1, LZB);
        wait_sb();

        // d1=3, d2=d3=0, ovf must stay set
        sweep(3);
        push(1'b0, "ovf_hold_slot1", 1, 7'h30, 1'b1, 1'b0);
        push(1'b0, "lzb_slot2", 2, 7'h40, 1'b1, LZB);
        push(1'b0, "lzb_slot3", 3, 7'h40, 1'b1, LZB);
        wait_sb();

        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        push(1'b0, "clr_slot1", 1, 7'h40, 1'b0, LZB);
        wait_sb();

        inc(5);
        push(1'b0, "d1_five", 1, 7'h12, 1'b0, 1'b0);
        wait_sb();
        clr   = 1'b1;
        rc_in = 1'b1;
        step();
        clr   = 1'b0;
        rc_in = 1'b0;
        step();
        push(1'b0, "clr_rc_slot1", 1, 7'h40, 1'b0, LZB);
        wait_sb();

        // Asynchronous blanking: checked before any clock edge arrives
        inc(2);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        compare("async_reset", an, seg, ovf, 4'hF, 8'hFF, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        compare("post_reset_first", an, seg, ovf, 4'hE, 8'h40, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
